// File: rtl/canvas_pkg.sv
// Shared constants, opcodes, command field positions and FSM state type for the canvas
// command controller.
package canvas_pkg;

    localparam int unsigned CANVAS_COLS = 512;
    localparam int unsigned CANVAS_ROWS = 256;
    localparam int unsigned COL_W       = $clog2(CANVAS_COLS);
    localparam int unsigned ROW_W       = $clog2(CANVAS_ROWS);
    // One extra bit so a full-width / full-height fill can count to its limit.
    localparam int unsigned XCNT_W      = COL_W + 1;
    localparam int unsigned YCNT_W      = ROW_W + 1;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned SCROLL_X_W  = 10;
    localparam int unsigned SCROLL_Y_W  = 9;
    localparam int unsigned PAL_ADDR_W  = 8;
    localparam int unsigned PAL_DATA_W  = 12;

    localparam logic [3:0] OP_NOP          = 4'h0;
    localparam logic [3:0] OP_SET_CURSOR   = 4'h1;
    localparam logic [3:0] OP_WRITE_PIXEL  = 4'h2;
    localparam logic [3:0] OP_SET_SCROLL_X = 4'h3;
    localparam logic [3:0] OP_SET_SCROLL_Y = 4'h4;
    localparam logic [3:0] OP_SET_PALETTE  = 4'h5;
    localparam logic [3:0] OP_FILL         = 4'h6;

    localparam int unsigned F_OP_LSB       = 28;
    localparam int unsigned F_COL_LSB      = 16;
    localparam int unsigned F_HGT_LSB      = 8;
    localparam int unsigned F_ROW_LSB      = 0;
    localparam int unsigned F_PIX_LSB      = 0;
    localparam int unsigned F_PAL_ADDR_LSB = 12;
    localparam int unsigned F_PAL_DATA_LSB = 0;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } ctrl_state_e;

    function automatic logic [3:0] cmd_opcode(input logic [31:0] cmd);
        return cmd[F_OP_LSB +: 4];
    endfunction

endpackage

// File: rtl/canvas_addr_gen.sv
// Cursor register with wrap-around advance and, when CANVAS_CMD_FILL_EN is defined,
// the fill raster counters that generate wrapped pixel addresses.
module canvas_addr_gen
    import canvas_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_set_cursor,
    input  logic [COL_W-1:0] i_col,
    input  logic [ROW_W-1:0] i_row,
    input  logic             i_advance,
`ifdef CANVAS_CMD_FILL_EN
    input  logic             i_fill_start,
    input  logic [COL_W-1:0] i_fill_w,
    input  logic [ROW_W-1:0] i_fill_h,
    input  logic             i_fill_step,
    output logic [COL_W-1:0] o_fill_col,
    output logic [ROW_W-1:0] o_fill_row,
    output logic             o_fill_last,
`endif
    output logic [COL_W-1:0] o_cur_col,
    output logic [ROW_W-1:0] o_cur_row
);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (i_set_cursor) begin
            col_q <= i_col;
            row_q <= i_row;
        end else if (i_advance) begin
            col_q <= col_q + COL_W'(1);
            if (col_q == COL_W'(CANVAS_COLS - 1)) begin
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

    assign o_cur_col = col_q;
    assign o_cur_row = row_q;

`ifdef CANVAS_CMD_FILL_EN
    logic [XCNT_W-1:0] x_q;
    logic [YCNT_W-1:0] y_q;
    logic [XCNT_W-1:0] w_q;
    logic [YCNT_W-1:0] h_q;
    logic              x_end;

    assign x_end = (x_q + XCNT_W'(1)) == w_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else if (i_fill_start) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= {1'b0, i_fill_w} + XCNT_W'(1);
            h_q <= {1'b0, i_fill_h} + YCNT_W'(1);
        end else if (i_fill_step) begin
            if (x_end) begin
                x_q <= '0;
                y_q <= y_q + YCNT_W'(1);
            end else begin
                x_q <= x_q + XCNT_W'(1);
            end
        end
    end

    // Native 9/8-bit overflow gives the modulo-canvas wrap.
    assign o_fill_col  = col_q + x_q[COL_W-1:0];
    assign o_fill_row  = row_q + y_q[ROW_W-1:0];
    assign o_fill_last = x_end && ((y_q + YCNT_W'(1)) == h_q);
`endif

endmodule

// File: rtl/canvas_cmd_ctrl.sv
// Canvas command controller: handshake, opcode decode, FSM and registered canvas outputs.
// Define CANVAS_CMD_FILL_EN to include the rectangular FILL command and FILL state.
module canvas_cmd_ctrl
    import canvas_pkg::*;
(
    input  logic                  i_cmd_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    input  logic [31:0]           i_cmd_data,
    output logic                  o_cmd_ready,
    output logic                  o_busy,
    output logic                  o_fb_we,
    output logic [COL_W-1:0]      o_fb_col,
    output logic [ROW_W-1:0]      o_fb_row,
    output logic [PIX_W-1:0]      o_fb_data,
    output logic [SCROLL_X_W-1:0] o_scroll_x,
    output logic [SCROLL_Y_W-1:0] o_scroll_y,
    output logic                  o_pal_we,
    output logic [PAL_ADDR_W-1:0] o_pal_addr,
    output logic [PAL_DATA_W-1:0] o_pal_data
);

    logic                  accept;
    logic [3:0]            opcode;
    logic                  set_cursor;
    logic                  advance;
    logic [COL_W-1:0]      cur_col;
    logic [ROW_W-1:0]      cur_row;
    logic                  unused_cmd_bits;

    logic                  ready_q, ready_d;
    logic                  fb_we_q, fb_we_d;
    logic [COL_W-1:0]      fb_col_q, fb_col_d;
    logic [ROW_W-1:0]      fb_row_q, fb_row_d;
    logic [PIX_W-1:0]      fb_data_q, fb_data_d;
    logic [SCROLL_X_W-1:0] scroll_x_q, scroll_x_d;
    logic [SCROLL_Y_W-1:0] scroll_y_q, scroll_y_d;
    logic                  pal_we_q, pal_we_d;
    logic [PAL_ADDR_W-1:0] pal_addr_q, pal_addr_d;
    logic [PAL_DATA_W-1:0] pal_data_q, pal_data_d;

`ifdef CANVAS_CMD_FILL_EN
    ctrl_state_e           state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  last_q, last_d;
    logic [PIX_W-1:0]      fill_colour_q, fill_colour_d;
    logic                  fill_start;
    logic                  fill_step;
    logic [COL_W-1:0]      fill_col;
    logic [ROW_W-1:0]      fill_row;
    logic                  fill_last;
`endif

    assign accept          = i_cmd_valid && ready_q;
    assign opcode          = cmd_opcode(i_cmd_data);
    assign unused_cmd_bits = ^i_cmd_data[27:25];

    canvas_addr_gen u_addr_gen (
        .i_clk        (i_cmd_clk),
        .i_rst        (i_rst),
        .i_set_cursor (set_cursor),
        .i_col        (i_cmd_data[F_COL_LSB +: COL_W]),
        .i_row        (i_cmd_data[F_ROW_LSB +: ROW_W]),
        .i_advance    (advance),
`ifdef CANVAS_CMD_FILL_EN
        .i_fill_start (fill_start),
        .i_fill_w     (i_cmd_data[F_COL_LSB +: COL_W]),
        .i_fill_h     (i_cmd_data[F_HGT_LSB +: ROW_W]),
        .i_fill_step  (fill_step),
        .o_fill_col   (fill_col),
        .o_fill_row   (fill_row),
        .o_fill_last  (fill_last),
`endif
        .o_cur_col    (cur_col),
        .o_cur_row    (cur_row)
    );

    always_comb begin
        ready_d    = 1'b1;
        fb_we_d    = 1'b0;
        fb_col_d   = fb_col_q;
        fb_row_d   = fb_row_q;
        fb_data_d  = fb_data_q;
        scroll_x_d = scroll_x_q;
        scroll_y_d = scroll_y_q;
        pal_we_d   = 1'b0;
        pal_addr_d = pal_addr_q;
        pal_data_d = pal_data_q;
        set_cursor = 1'b0;
        advance    = 1'b0;
`ifdef CANVAS_CMD_FILL_EN
        state_d       = state_q;
        busy_d        = busy_q;
        last_d        = last_q;
        fill_colour_d = fill_colour_q;
        fill_start    = 1'b0;
        fill_step     = 1'b0;
        if (state_q == StFill) begin
            ready_d = 1'b0;
            // One trailing cycle after the last write keeps occupancy at W*H+1.
            if (last_q) begin
                state_d = StIdle;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end else begin
                fb_we_d   = 1'b1;
                fb_col_d  = fill_col;
                fb_row_d  = fill_row;
                fb_data_d = fill_colour_q;
                fill_step = 1'b1;
                last_d    = fill_last;
            end
        end else
`endif
        if (accept) begin
            case (opcode)
                OP_SET_CURSOR:   set_cursor = 1'b1;
                OP_WRITE_PIXEL: begin
                    fb_we_d   = 1'b1;
                    fb_col_d  = cur_col;
                    fb_row_d  = cur_row;
                    fb_data_d = i_cmd_data[F_PIX_LSB +: PIX_W];
                    advance   = 1'b1;
                end
                OP_SET_SCROLL_X: scroll_x_d = i_cmd_data[SCROLL_X_W-1:0];
                OP_SET_SCROLL_Y: scroll_y_d = i_cmd_data[SCROLL_Y_W-1:0];
                OP_SET_PALETTE: begin
                    pal_we_d   = 1'b1;
                    pal_addr_d = i_cmd_data[F_PAL_ADDR_LSB +: PAL_ADDR_W];
                    pal_data_d = i_cmd_data[F_PAL_DATA_LSB +: PAL_DATA_W];
                end
`ifdef CANVAS_CMD_FILL_EN
                OP_FILL: begin
                    state_d       = StFill;
                    ready_d       = 1'b0;
                    busy_d        = 1'b1;
                    fill_start    = 1'b1;
                    fill_colour_d = i_cmd_data[F_PIX_LSB +: PIX_W];
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_cmd_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_col_q   <= '0;
            fb_row_q   <= '0;
            fb_data_q  <= '0;
            scroll_x_q <= '0;
            scroll_y_q <= '0;
            pal_we_q   <= 1'b0;
            pal_addr_q <= '0;
            pal_data_q <= '0;
        end else begin
            ready_q    <= ready_d;
            fb_we_q    <= fb_we_d;
            fb_col_q   <= fb_col_d;
            fb_row_q   <= fb_row_d;
            fb_data_q  <= fb_data_d;
            scroll_x_q <= scroll_x_d;
            scroll_y_q <= scroll_y_d;
            pal_we_q   <= pal_we_d;
            pal_addr_q <= pal_addr_d;
            pal_data_q <= pal_data_d;
        end
    end

`ifdef CANVAS_CMD_FILL_EN
    always_ff @(posedge i_cmd_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            last_q        <= 1'b0;
            fill_colour_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            last_q        <= last_d;
            fill_colour_q <= fill_colour_d;
        end
    end

    assign o_busy = busy_q;
`else
    assign o_busy = 1'b0;
`endif

    assign o_cmd_ready = ready_q;
    assign o_fb_we     = fb_we_q;
    assign o_fb_col    = fb_col_q;
    assign o_fb_row    = fb_row_q;
    assign o_fb_data   = fb_data_q;
    assign o_scroll_x  = scroll_x_q;
    assign o_scroll_y  = scroll_y_q;
    assign o_pal_we    = pal_we_q;
    assign o_pal_addr  = pal_addr_q;
    assign o_pal_data  = pal_data_q;

endmodule

// File: tb/tb_canvas_cmd_ctrl.sv
// Directed self-checking bench for canvas_cmd_ctrl; covers FILL when CANVAS_CMD_FILL_EN
// is defined, otherwise checks that opcode 0x6 is inert.
module tb_canvas_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] data = '0;

    logic        o_cmd_ready, o_busy, o_fb_we, o_pal_we;
    logic [8:0]  o_fb_col;
    logic [7:0]  o_fb_row, o_fb_data, o_pal_addr;
    logic [9:0]  o_scroll_x;
    logic [8:0]  o_scroll_y;
    logic [11:0] o_pal_data;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt;
    int nwr;

    canvas_cmd_ctrl dut (
        .i_cmd_clk   (clk),
        .i_rst       (rst),
        .i_cmd_valid (valid),
        .i_cmd_data  (data),
        .o_cmd_ready (o_cmd_ready),
        .o_busy      (o_busy),
        .o_fb_we     (o_fb_we),
        .o_fb_col    (o_fb_col),
        .o_fb_row    (o_fb_row),
        .o_fb_data   (o_fb_data),
        .o_scroll_x  (o_scroll_x),
        .o_scroll_y  (o_scroll_y),
        .o_pal_we    (o_pal_we),
        .o_pal_addr  (o_pal_addr),
        .o_pal_data  (o_pal_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        valid = 1'b1;
        data  = d;
        tick();
    endtask

    // Junk WRITE_PIXEL word with valid low must be ignored.
    task automatic idle();
        valid = 1'b0;
        data  = 32'h2000_00EE;
        tick();
    endtask

    function automatic logic [31:0] mk_cursor(input logic [8:0] c, input logic [7:0] r);
        return {4'h1, 3'b000, c, 8'h00, r};
    endfunction

    function automatic logic [31:0] mk_write(input logic [7:0] d);
        return {4'h2, 20'h0, d};
    endfunction

    function automatic logic [31:0] mk_fill(input logic [8:0] wm1, input logic [7:0] hm1,
                                            input logic [7:0] c);
        return {4'h6, 3'b000, wm1, hm1, c};
    endfunction

    function automatic logic [31:0] fb_exp(input logic we, input logic [8:0] c,
                                           input logic [7:0] r, input logic [7:0] d);
        return {6'h0, we, c, r, d};
    endfunction

    function automatic logic [31:0] fb_now();
        return {6'h0, o_fb_we, o_fb_col, o_fb_row, o_fb_data};
    endfunction

`ifdef CANVAS_CMD_FILL_EN
    logic [8:0] fc [6] = '{9'd510, 9'd511, 9'd0, 9'd510, 9'd511, 9'd0};
    logic [7:0] fr [6] = '{8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255};
`endif

    initial begin
        repeat (3) tick();
        check("rst_ready", {31'h0, o_cmd_ready}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_fb", fb_now(), 32'h0);
        check("rst_scroll", {13'h0, o_scroll_x, o_scroll_y}, 32'h0);
        check("rst_pal", {11'h0, o_pal_we, o_pal_addr, o_pal_data}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", {31'h0, o_cmd_ready}, 32'h0);
        tick();
        check("ready_after_edge", {31'h0, o_cmd_ready}, 32'h1);

        send(mk_cursor(9'd511, 8'd255));
        check("cursor_nowrite", {31'h0, o_fb_we}, 32'h0);
        send(mk_write(8'hAB));
        check("wr_511_255", fb_now(), fb_exp(1'b1, 9'd511, 8'd255, 8'hAB));
        send(mk_write(8'hAB));
        check("wr_wrap_0_0", fb_now(), fb_exp(1'b1, 9'd0, 8'd0, 8'hAB));
        send(mk_write(8'h01));
        check("wr_1_0", fb_now(), fb_exp(1'b1, 9'd1, 8'd0, 8'h01));
        idle();
        check("fb_hold", fb_now(), fb_exp(1'b0, 9'd1, 8'd0, 8'h01));

        send(32'h3000_03FF);
        check("scroll_x", {22'h0, o_scroll_x}, 32'h3FF);
        send(32'h4000_01FF);
        check("scroll_xy", {13'h0, o_scroll_x, o_scroll_y}, {13'h0, 10'h3FF, 9'h1FF});
        send(32'h5001_2F0A);
        check("pal_pulse", {11'h0, o_pal_we, o_pal_addr, o_pal_data}, {11'h0, 1'b1, 8'h12, 12'hF0A});
        idle();
        check("pal_single", {11'h0, o_pal_we, o_pal_addr, o_pal_data}, {11'h0, 1'b0, 8'h12, 12'hF0A});

        send(32'h3000_0155);
        check("scroll_x_155", {22'h0, o_scroll_x}, 32'h155);
        send(32'h0FFF_FFFF);
        check("nop0", {10'h0, o_fb_we, o_pal_we, o_cmd_ready, o_scroll_x, o_scroll_y},
              {10'h0, 1'b0, 1'b0, 1'b1, 10'h155, 9'h1FF});
        send(32'h7FFF_FFFF);
        check("nop7", {10'h0, o_fb_we, o_pal_we, o_cmd_ready, o_scroll_x, o_scroll_y},
              {10'h0, 1'b0, 1'b0, 1'b1, 10'h155, 9'h1FF});
        send(32'hF123_4567);
        check("nopF", {10'h0, o_fb_we, o_pal_we, o_cmd_ready, o_scroll_x, o_scroll_y},
              {10'h0, 1'b0, 1'b0, 1'b1, 10'h155, 9'h1FF});

`ifdef CANVAS_CMD_FILL_EN
        send(mk_cursor(9'd510, 8'd254));
        send(mk_fill(9'd2, 8'd1, 8'h55));
        valid = 1'b0;
        check("fill_accept", {29'h0, o_fb_we, o_cmd_ready, o_busy}, {29'h0, 3'b001});
        busy_cnt = o_busy ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("fill_px%0d", i), fb_now(), fb_exp(1'b1, fc[i], fr[i], 8'h55));
            if (o_busy) busy_cnt++;
        end
        tick();
        check("fill_done", {29'h0, o_fb_we, o_cmd_ready, o_busy}, {29'h0, 3'b010});
        check("fill_busy_cycles", busy_cnt, 32'd7);
        send(mk_write(8'h11));
        check("fill_cursor_kept", fb_now(), fb_exp(1'b1, 9'd510, 8'd254, 8'h11));

        send(mk_cursor(9'd100, 8'd10));
        send(mk_fill(9'd3, 8'd0, 8'h33));
        data = mk_write(8'h77);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("held_px%0d", i), fb_now(), fb_exp(1'b1, 9'(100 + i), 8'd10, 8'h33));
        end
        tick();
        check("held_ready_back", {30'h0, o_fb_we, o_cmd_ready}, {30'h0, 2'b01});
        tick();
        check("held_accepted", fb_now(), fb_exp(1'b1, 9'd100, 8'd10, 8'h77));
        valid = 1'b0;
        nwr = 0;
        repeat (3) begin
            tick();
            if (o_fb_we) nwr++;
        end
        check("held_no_dup", nwr, 32'd0);
        send(mk_write(8'h78));
        check("held_cursor_once", fb_now(), fb_exp(1'b1, 9'd101, 8'd10, 8'h78));

        send(mk_cursor(9'd7, 8'd3));
        send(mk_fill(9'd15, 8'd0, 8'h99));
        valid = 1'b0;
        tick();
        tick();
        check("fill16_2nd_write", fb_now(), fb_exp(1'b1, 9'd8, 8'd3, 8'h99));
`else
        send(mk_fill(9'd3, 8'd0, 8'h66));
        check("op6_accept", {29'h0, o_fb_we, o_cmd_ready, o_busy}, {29'h0, 3'b010});
        idle();
        check("op6_no_write", {29'h0, o_fb_we, o_cmd_ready, o_busy}, {29'h0, 3'b010});
        send(mk_write(8'h21));
        check("op6_cursor_kept", fb_now(), fb_exp(1'b1, 9'd2, 8'd0, 8'h21));

        send(mk_cursor(9'd7, 8'd3));
        send(mk_write(8'h5A));
        check("wr_before_rst", fb_now(), fb_exp(1'b1, 9'd7, 8'd3, 8'h5A));
`endif

        valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_abort_we", {31'h0, o_fb_we}, 32'h0);
        check("rst_abort_ready_busy", {30'h0, o_cmd_ready, o_busy}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        nwr = 0;
        repeat (20) begin
            tick();
            if (o_fb_we) nwr++;
        end
        check("post_rst_writes", nwr, 32'd0);
        check("post_rst_ready", {31'h0, o_cmd_ready}, 32'h1);
        check("post_rst_scroll", {13'h0, o_scroll_x, o_scroll_y}, 32'h0);
        send(mk_write(8'h42));
        check("post_rst_cursor", fb_now(), fb_exp(1'b1, 9'd0, 8'd0, 8'h42));
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/canvas_cmd_ctrl.md
# canvas_cmd_ctrl

Command controller for the scrolling background canvas. Accepts 32-bit commands on the command clock with a valid/ready handshake and drives the canvas on that clock:
- the frame buffer write port (port A)
- the scroll offset registers
- palette write strobes

It also sequences multi-cycle rectangular fills, one pixel per clock. It sits between the host command interface and the canvas datapath.

## Interface
- No parameters; dimensions come from the shared package (canvas 512 columns × 256 rows).
- i_cmd_clk  in  1  sole clock; all state changes on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command word present.
- i_cmd_data  in  32  command word; [31:28] opcode.
- o_cmd_ready  out  1  controller accepts a command this cycle.
- o_busy  out  1  fill in progress.
- o_fb_we  out  1  frame buffer port A write enable.
- o_fb_col  out  9  port A column.
- o_fb_row  out  8  port A row.
- o_fb_data  out  8  port A pixel (palette index).
- o_scroll_x  out  10  horizontal scroll offset.
- o_scroll_y  out  9  vertical scroll offset.
- o_pal_we  out  1  palette write strobe.
- o_pal_addr  out  8  palette index.
- o_pal_data  out  12  palette colour (4:4:4).

## Operation
- Acceptance: a command is accepted when i_cmd_valid && o_cmd_ready. When not accepted, i_cmd_data is ignored.
- Internal state: cursor (col 9b, row 8b), reset to 0,0.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 SET_CURSOR: col=[24:16], row=[7:0].
  - 0x2 WRITE_PIXEL: write [7:0] at cursor. Cursor col+1; on col 511→0, row+1; row 255→0.
  - 0x3 SET_SCROLL_X: o_scroll_x=[9:0], stored unmodified.
  - 0x4 SET_SCROLL_Y: o_scroll_y=[8:0].
  - 0x5 SET_PALETTE: o_pal_addr=[19:12], o_pal_data=[11:0], o_pal_we pulse.
  - 0x6 FILL: fills a rectangle anchored at the cursor.
    - Width = [24:16]+1 (1..512). Height = [15:8]+1 (1..256). Colour = [7:0].
    - Column and row each wrap modulo canvas size.
    - Cursor unchanged.
  - 0x7–0xF: treated as NOP (accepted, no effect).
- FSM states:
  - IDLE: ready=1. Single-cycle opcodes execute here. FILL moves to FILL.
  - FILL: ready=0, busy=1. Raster order, row-major: x 0..W-1, then y+1. After the last pixel, return to IDLE.
- Arithmetic:
  - Address = (cursor_col + x) mod 512 and (cursor_row + y) mod 256. Native 9/8-bit overflow provides the wrap.
  - x/y counters are 10/9 bits so that W=512 and H=256 terminate correctly.
- o_fb_col/row/data hold their last written values when o_fb_we=0.

## Timing
- All outputs are registered.
- Reset values:
  - o_cmd_ready=0; rises on the first clock edge after i_rst deasserts.
  - All other outputs 0; cursor 0; FSM IDLE.
- Single-cycle commands: accepted on edge N; effect visible after edge N (o_fb_we/o_pal_we high for exactly one cycle). Back-to-back acceptance every cycle is sustained.
- FILL:
  - Accepted on edge N.
  - o_cmd_ready and o_busy change after edge N.
  - First write is presented after edge N+1.
  - W×H consecutive o_fb_we cycles.
  - o_busy falls and o_cmd_ready rises after the edge that completes the last write.
  - Total occupancy: W×H+1 cycles.
- WRITE_PIXEL immediately following SET_CURSOR uses the new cursor.
- Reset asserted mid-fill: immediate abort. Write enables drop asynchronously and the cursor is cleared. No further writes occur.
- i_cmd_valid held high while ready=0: the command is held by the sender and accepted once ready returns. Nothing is dropped or duplicated.

## Configuration
- CANVAS_CMD_FILL_EN defined: FILL opcode, FILL state and x/y counters are present.
- Undefined:
  - 0x6 decodes as NOP.
  - o_busy is tied 0 and o_cmd_ready stays 1 after the first post-reset edge.
  - The FSM has IDLE only.

## Structure
- Shared package canvas_pkg:
  - CANVAS_COLS=512, CANVAS_ROWS=256
  - opcode localparams OP_NOP…OP_FILL
  - FSM state typedef
  - command field bit positions
- Sub-module canvas_addr_gen holds the cursor register, the wrap-around advance, and the fill x/y raster counters with a last-pixel flag. The top level holds decode, the FSM and the output registers.

## Test plan
- Reset release: all outputs 0 during reset. o_cmd_ready=1 one edge after release.
- SET_CURSOR(511,255), then WRITE_PIXEL 0xAB ×2: writes (511,255)=0xAB, then (0,0)=0xAB. Cursor ends at (1,0).
- SET_SCROLL_X 0x3FF, SET_SCROLL_Y 0x1FF, SET_PALETTE idx 0x12 colour 0xF0A on consecutive cycles: outputs update on successive edges; o_pal_we is a single pulse with addr 0x12, data 0xF0A.
- Cursor (510,254), FILL W=3 H=2 colour 0x55: writes (510,254),(511,254),(0,254),(510,255),(511,255),(0,255). o_busy is high for 7 cycles. Cursor unchanged.
- FILL W=4 H=1 with valid held high on the next command: that command is accepted exactly once, on the cycle ready returns.
- Reset asserted at the 2nd write of a 16-pixel fill: o_fb_we=0 immediately and no later writes. With CANVAS_CMD_FILL_EN undefined, opcode 0x6 produces no write and ready stays 1.
